// File: rtl/xalu_muldiv.sv
// xalu_muldiv: multi-cycle integer multiply/divide unit holding the
// architectural HI/LO registers for the execute stage.
// mult/multu/mul complete after MUL_LAT busy cycles; div/divu use a radix-2
// restoring divider (32 iterations plus a sign-fixup cycle).
// Optional build macro XALU_DIV_EARLY_EN: divides whose quotient is trivially
// zero (divisor 0 or |dividend| < |divisor|) skip the iteration phase.
module xalu_muldiv #(
  parameter int MUL_LAT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mul_result,
  output logic        mul_valid
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MUL   = 3'd6;

  localparam logic [4:0] MUL_CNT_INIT = 5'(MUL_LAT - 1);
  localparam logic [4:0] DIV_LAST     = 5'd31;

`ifdef XALU_DIV_EARLY_EN
  localparam logic EARLY_EN = 1'b1;
`else
  localparam logic EARLY_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_t;

  state_t      state_r;
  logic [4:0]  cnt_r;
  logic        busy_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic [31:0] mul_result_r;
  logic        mul_valid_r;

  // Operands captured at issue
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic        mul_signed_r;
  logic        mul_low_r;

  // Divider state
  logic [31:0] quo_r;
  logic [31:0] rem_r;
  logic [31:0] dvs_r;
  logic        q_neg_r;
  logic        r_neg_r;
  logic        div_zero_r;
  logic        early_r;

  // Combinational helpers
  logic        div_signed_s;
  logic [31:0] a_mag_s;
  logic [31:0] b_mag_s;
  logic        early_s;
  logic [63:0] a_ext_s;
  logic [63:0] b_ext_s;
  logic [63:0] prod_s;
  logic [32:0] rem_shift_s;
  logic        rem_ge_s;
  logic [31:0] rem_sub_s;
  logic [31:0] rem_next_s;
  logic [31:0] quo_next_s;
  logic [31:0] q_fix_s;
  logic [31:0] r_fix_s;

  // Operand magnitudes and early-out detection for a divide being issued.
  always_comb begin
    div_signed_s = (op == OP_DIV);
    a_mag_s      = (div_signed_s && a[31]) ? (32'd0 - a) : a;
    b_mag_s      = (div_signed_s && b[31]) ? (32'd0 - b) : b;
    early_s      = EARLY_EN && ((b_mag_s == 32'd0) || (a_mag_s < b_mag_s));
  end

  // 64-bit product of the captured operands; low 64 bits of the
  // sign/zero-extended product are exact for both signednesses.
  always_comb begin
    a_ext_s = {{32{mul_signed_r & a_r[31]}}, a_r};
    b_ext_s = {{32{mul_signed_r & b_r[31]}}, b_r};
    prod_s  = a_ext_s * b_ext_s;
  end

  // One restoring-division step: shift in the next dividend bit and subtract
  // the divisor when it fits (the difference always fits in 32 bits).
  always_comb begin
    rem_shift_s = {rem_r, quo_r[31]};
    rem_ge_s    = (rem_shift_s >= {1'b0, dvs_r});
    rem_sub_s   = rem_shift_s[31:0] - dvs_r;
    if (rem_ge_s) begin
      rem_next_s = rem_sub_s;
    end else begin
      rem_next_s = rem_shift_s[31:0];
    end
    quo_next_s = {quo_r[30:0], rem_ge_s};
  end

  // Sign fixup: quotient negative when signs differ, remainder follows dividend.
  always_comb begin
    q_fix_s = q_neg_r ? (32'd0 - quo_r) : quo_r;
    r_fix_s = r_neg_r ? (32'd0 - rem_r) : rem_r;
  end

  // Control FSM, operand capture, divider iteration and architectural registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 5'd0;
      busy_r       <= 1'b0;
      hi_r         <= 32'd0;
      lo_r         <= 32'd0;
      mul_result_r <= 32'd0;
      mul_valid_r  <= 1'b0;
      a_r          <= 32'd0;
      b_r          <= 32'd0;
      mul_signed_r <= 1'b0;
      mul_low_r    <= 1'b0;
      quo_r        <= 32'd0;
      rem_r        <= 32'd0;
      dvs_r        <= 32'd0;
      q_neg_r      <= 1'b0;
      r_neg_r      <= 1'b0;
      div_zero_r   <= 1'b0;
      early_r      <= 1'b0;
    end else if (flush) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 5'd0;
      busy_r      <= 1'b0;
      mul_valid_r <= 1'b0;
    end else begin
      mul_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU, OP_MUL: begin
                a_r          <= a;
                b_r          <= b;
                mul_signed_r <= (op != OP_MULTU);
                mul_low_r    <= (op == OP_MUL);
                cnt_r        <= MUL_CNT_INIT;
                busy_r       <= 1'b1;
                state_r      <= ST_MUL;
              end
              OP_DIV, OP_DIVU: begin
                a_r        <= a;
                b_r        <= b;
                dvs_r      <= b_mag_s;
                q_neg_r    <= div_signed_s & (a[31] ^ b[31]);
                r_neg_r    <= div_signed_s & a[31];
                div_zero_r <= (b == 32'd0);
                early_r    <= early_s;
                cnt_r      <= 5'd0;
                busy_r     <= 1'b1;
                state_r    <= ST_DIV;
                if (early_s) begin
                  quo_r <= 32'd0;
                  rem_r <= a_mag_s;
                end else begin
                  quo_r <= a_mag_s;
                  rem_r <= 32'd0;
                end
              end
              OP_MTHI: hi_r <= a;
              OP_MTLO: lo_r <= a;
              default: ;
            endcase
          end
        end
        ST_MUL: begin
          if (cnt_r == 5'd0) begin
            if (mul_low_r) begin
              mul_result_r <= prod_s[31:0];
              mul_valid_r  <= 1'b1;
            end else begin
              hi_r <= prod_s[63:32];
              lo_r <= prod_s[31:0];
            end
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r - 5'd1;
          end
        end
        ST_DIV: begin
          if (early_r) begin
            state_r <= ST_FIX;
          end else begin
            quo_r <= quo_next_s;
            rem_r <= rem_next_s;
            cnt_r <= cnt_r + 5'd1;
            if (cnt_r == DIV_LAST) begin
              state_r <= ST_FIX;
            end else begin
              state_r <= ST_DIV;
            end
          end
        end
        ST_FIX: begin
          if (div_zero_r) begin
            lo_r <= 32'hFFFF_FFFF;
            hi_r <= a_r;
          end else begin
            lo_r <= q_fix_s;
            hi_r <= r_fix_s;
          end
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_r;
  assign hi         = hi_r;
  assign lo         = lo_r;
  assign mul_result = mul_result_r;
  assign mul_valid  = mul_valid_r;

endmodule

// File: tb/tb_xalu_muldiv.sv
// Self-checking bench for xalu_muldiv: a reference model pushes expected
// results into a scoreboard at issue; they are popped when busy drops.
module tb_xalu_muldiv;

  localparam int MUL_LAT = 4;
  localparam int TIMEOUT = 200;
`ifdef XALU_DIV_EARLY_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mul_result;
  logic        mul_valid;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mr;
    logic        mv;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [31:0] m_mr;
  int          tests = 0;
  int          fails = 0;
  int          busy_start_err = 0;

  xalu_muldiv #(.MUL_LAT(MUL_LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .flush      (flush),
    .busy       (busy),
    .hi         (hi),
    .lo         (lo),
    .mul_result (mul_result),
    .mul_valid  (mul_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A start while busy must never be presented by the hazard unit.
  always @(posedge clk) begin
    if (start === 1'b1 && busy === 1'b1 && reset === 1'b0) begin
      busy_start_err <= busy_start_err + 1;
    end
  end

  function automatic exp_t model(input logic [2:0] mop, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    longint sp;
    longint unsigned up;
    longint xl, yl, xm, ym;
    int xi, yi, sq, sr;
    e.hi = m_hi; e.lo = m_lo; e.mr = m_mr; e.mv = 1'b0; e.lat = 0;
    xi = x; yi = y;
    case (mop)
      3'd0: begin
        sp = longint'(xi) * longint'(yi);
        e.hi = sp[63:32]; e.lo = sp[31:0]; e.lat = MUL_LAT;
      end
      3'd1: begin
        up = {32'd0, x} * {32'd0, y};
        e.hi = up[63:32]; e.lo = up[31:0]; e.lat = MUL_LAT;
      end
      3'd6: begin
        sp = longint'(xi) * longint'(yi);
        e.mr = sp[31:0]; e.mv = 1'b1; e.lat = MUL_LAT;
      end
      3'd2: begin
        if (y == 32'd0) begin
          e.lo = 32'hFFFF_FFFF; e.hi = x;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          e.lo = 32'h8000_0000; e.hi = 32'd0;
        end else begin
          sq = xi / yi; sr = xi % yi;
          e.lo = 32'(sq); e.hi = 32'(sr);
        end
        xl = longint'(xi); yl = longint'(yi);
        xm = (xl < 0) ? -xl : xl;
        ym = (yl < 0) ? -yl : yl;
        e.lat = (EARLY && (ym == 0 || xm < ym)) ? 2 : 33;
      end
      3'd3: begin
        if (y == 32'd0) begin
          e.lo = 32'hFFFF_FFFF; e.hi = x;
        end else begin
          e.lo = x / y; e.hi = x % y;
        end
        xm = longint'({32'd0, x}); ym = longint'({32'd0, y});
        e.lat = (EARLY && (ym == 0 || xm < ym)) ? 2 : 33;
      end
      3'd4: e.hi = x;
      3'd5: e.lo = x;
      default: ;
    endcase
    return e;
  endfunction

  task automatic issue(input logic [2:0] mop, input logic [31:0] x, input logic [31:0] y);
    op = mop; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = 3'd7; a = $urandom; b = $urandom;
  endtask

  task automatic run_op(input string name, input logic [2:0] mop, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    int cyc;
    sb_q.push_back(model(mop, x, y));
    issue(mop, x, y);
    cyc = 0;
    while (busy === 1'b1 && cyc < TIMEOUT) begin
      cyc++;
      @(negedge clk);
    end
    e = sb_q.pop_front();
    tests++;
    if (cyc !== e.lat) begin fails++; $display("FAIL %s busy_cycles: got %0d, expected %0d", name, cyc, e.lat); end
    tests++;
    if (hi !== e.hi) begin fails++; $display("FAIL %s hi: got %h, expected %h", name, hi, e.hi); end
    tests++;
    if (lo !== e.lo) begin fails++; $display("FAIL %s lo: got %h, expected %h", name, lo, e.lo); end
    tests++;
    if (mul_result !== e.mr) begin fails++; $display("FAIL %s mul_result: got %h, expected %h", name, mul_result, e.mr); end
    tests++;
    if (mul_valid !== e.mv) begin fails++; $display("FAIL %s mul_valid: got %b, expected %b", name, mul_valid, e.mv); end
    m_hi = e.hi; m_lo = e.lo; m_mr = e.mr;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd7; a = 32'd0; b = 32'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0; m_mr = 32'd0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset busy: got %b, expected 0", busy); end
    tests++; if (hi !== 32'd0) begin fails++; $display("FAIL reset hi: got %h, expected 0", hi); end
    tests++; if (lo !== 32'd0) begin fails++; $display("FAIL reset lo: got %h, expected 0", lo); end
    tests++; if (mul_result !== 32'd0) begin fails++; $display("FAIL reset mul_result: got %h, expected 0", mul_result); end
    tests++; if (mul_valid !== 1'b0) begin fails++; $display("FAIL reset mul_valid: got %b, expected 0", mul_valid); end
  endtask

  task automatic test_mult;
    run_op("mult", 3'd0, 32'hFFFF_FFFE, 32'd3);
    tests++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin fails++; $display("FAIL mult_const: got %h_%h, expected ffffffff_fffffffa", hi, lo); end
    run_op("multu", 3'd1, 32'hFFFF_FFFE, 32'd3);
    tests++; if (hi !== 32'd2 || lo !== 32'hFFFF_FFFA) begin fails++; $display("FAIL multu_const: got %h_%h, expected 00000002_fffffffa", hi, lo); end
    run_op("mult_negneg", 3'd0, 32'h8000_0000, 32'h8000_0000);
    run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
  endtask

  task automatic test_div;
    run_op("div_neg7_2", 3'd2, 32'hFFFF_FFF9, 32'd2);
    tests++; if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin fails++; $display("FAIL div_const: got hi=%h lo=%h, expected hi=ffffffff lo=fffffffd", hi, lo); end
    run_op("divu_by0", 3'd3, 32'd7, 32'd0);
    tests++; if (lo !== 32'hFFFF_FFFF || hi !== 32'd7) begin fails++; $display("FAIL divu0_const: got hi=%h lo=%h, expected hi=00000007 lo=ffffffff", hi, lo); end
    run_op("div_by0", 3'd2, 32'hFFFF_FF9C, 32'd0);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div_7_neg2", 3'd2, 32'd7, 32'hFFFF_FFFE);
    run_op("divu_big", 3'd3, 32'hFFFF_FFFF, 32'd3);
    run_op("divu_small", 3'd3, 32'd5, 32'd9);
    run_op("div_small_neg", 3'd2, 32'hFFFF_FFFB, 32'd9);
    run_op("div_mid", 3'd2, 32'h1234_5678, 32'h0000_1000);
  endtask

  task automatic test_mtlo_mul;
    run_op("mtlo", 3'd5, 32'h0000_1234, 32'd0);
    run_op("mul", 3'd6, 32'd5, 32'hFFFF_FFFD);
    tests++; if (mul_result !== 32'hFFFF_FFF1 || lo !== 32'h0000_1234) begin fails++; $display("FAIL mul_const: got mr=%h lo=%h, expected mr=fffffff1 lo=00001234", mul_result, lo); end
    @(negedge clk);
    tests++; if (mul_valid !== 1'b0) begin fails++; $display("FAIL mul_valid_width: got %b, expected 0", mul_valid); end
    run_op("mthi", 3'd4, 32'hCAFE_F00D, 32'd0);
  endtask

  task automatic test_flush;
    int saw_mv;
    issue(3'd2, 32'd1000, 32'd7);
    for (int i = 1; i < 10; i++) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL flush_div busy: got %b, expected 0", busy); end
    for (int i = 0; i < 40; i++) @(negedge clk);
    tests++; if (hi !== m_hi || lo !== m_lo) begin fails++; $display("FAIL flush_div hilo: got %h_%h, expected %h_%h", hi, lo, m_hi, m_lo); end
    issue(3'd6, 32'd7, 32'd9);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    saw_mv = 0;
    for (int i = 0; i < MUL_LAT + 2; i++) begin
      if (mul_valid === 1'b1) saw_mv++;
      @(negedge clk);
    end
    tests++; if (saw_mv !== 0 || mul_result !== m_mr) begin fails++; $display("FAIL flush_mul: got pulses=%0d mr=%h, expected pulses=0 mr=%h", saw_mv, mul_result, m_mr); end
    op = 3'd4; a = 32'hDEAD_BEEF; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    tests++; if (busy !== 1'b0 || hi !== m_hi) begin fails++; $display("FAIL start_flush_mthi: got busy=%b hi=%h, expected busy=0 hi=%h", busy, hi, m_hi); end
    op = 3'd2; a = 32'd50; b = 32'd3; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    tests++; if (busy !== 1'b0 || lo !== m_lo) begin fails++; $display("FAIL start_flush_div: got busy=%b lo=%h, expected busy=0 lo=%h", busy, lo, m_lo); end
  endtask

  task automatic test_reset_mid;
    run_op("pre_mthi", 3'd4, 32'hA5A5_A5A5, 32'd0);
    run_op("pre_mtlo", 3'd5, 32'h5A5A_5A5A, 32'd0);
    issue(3'd2, 32'd12345, 32'd17);
    for (int i = 0; i < 5; i++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0; m_mr = 32'd0;
    tests++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin fails++; $display("FAIL reset_mid: got busy=%b hi=%h lo=%h, expected all 0", busy, hi, lo); end
    run_op("mult_after_reset", 3'd0, 32'h0001_0000, 32'h0001_0000);
  endtask

  task automatic test_back_to_back;
    logic [2:0]  mop;
    logic [31:0] x, y;
    int          sel;
    for (int i = 0; i < 30; i++) begin
      mop = 3'($urandom_range(0, 6));
      sel = $urandom_range(0, 3);
      x = $urandom; y = $urandom;
      if (sel == 0) y = 32'd0;
      else if (sel == 1) begin x = 32'($urandom_range(0, 20)); y = 32'($urandom_range(1, 40)); end
      run_op("b2b", mop, x, y);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mtlo_mul();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    tests++;
    if (busy_start_err !== 0) begin fails++; $display("FAIL start_while_busy: got %0d, expected 0", busy_start_err); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/xalu_muldiv.md
# xalu_muldiv

Multi-cycle integer multiply/divide unit with architectural HI/LO registers, sitting in the execute stage beside the main ALU. It accepts MIPS mult/multu/div/divu/mul/mthi/mtlo operations from the decode/execute boundary and holds them for several cycles. Its `busy` output is the `XALU_Busy` signal the decode-stage hazard unit uses to stall any later multiply-family instruction (mult/multu/div/divu/mul/mfhi/mflo/mthi/mtlo). HI/LO are read combinationally by the execute stage for mfhi/mflo.

## Interface
- `MUL_LAT`, default 4: busy cycles for mult/multu/mul, legal range 1..8.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  operation issue strobe, sampled at the rising edge.
- `op`  in  3  operation code: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 mul; code 7 is a no-op.
- `a`  in  32  rs operand: multiplicand, dividend, or mthi/mtlo data.
- `b`  in  32  rt operand: multiplier or divisor.
- `flush`  in  1  exception flush; aborts the in-flight operation and blocks a same-cycle start.
- `busy`  out  1  a multi-cycle operation is in flight (XALU_Busy).
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.
- `mul_result`  out  32  low 32 bits of the last completed mul.
- `mul_valid`  out  1  one-cycle pulse when `mul_result` is updated.

## Operation
- States: IDLE, MUL, DIV, FIX.
  - IDLE -> MUL on start with op 0, 1 or 6.
  - IDLE -> DIV on start with op 2 or 3.
  - DIV -> FIX after the 32nd iteration.
  - MUL or FIX -> IDLE on completion.
- Any state -> IDLE on flush.
- A start outside IDLE is ignored. The hazard unit guarantees this never happens; the bench treats it as an assertion failure.
- mult/multu: 64-bit product of `a`*`b`, signed or unsigned. HI gets product[63:32], LO gets product[31:0].
- mul: signed product; `mul_result` gets product[31:0]. HI/LO are unchanged.
- div/divu: radix-2 restoring division on magnitudes over 32 iterations (one per cycle in DIV). FIX applies the signs and writes LO = quotient, HI = remainder.
- Signed division truncates toward zero. The remainder takes the sign of the dividend.
- Divide by zero (signed or unsigned): LO = 32'hFFFFFFFF, HI = `a`.
- Signed 32'h80000000 / 32'hFFFFFFFF: LO = 32'h80000000, HI = 0.
- mthi/mtlo: HI or LO gets `a` at the sampling edge. No busy. Accepted only in IDLE.
- Operands are latched at start; later changes on `a`/`b` have no effect.
- flush: abandons the operation. HI, LO and `mul_result` keep their pre-start values; no `mul_valid`. A start in the same cycle as flush is dropped, including mthi/mtlo.
- reset: all state returns to IDLE regardless of progress.

## Timing
- Reset values: `busy` 0, `hi` 0, `lo` 0, `mul_result` 0, `mul_valid` 0, state IDLE.
- Start sampled at edge E0. `busy` rises after E0.
- mult/multu/mul: `busy` is high for exactly MUL_LAT cycles. HI/LO or `mul_result` update at the same edge where `busy` falls. `mul_valid` is high for the one cycle after that edge.
- div/divu: `busy` is high for 33 cycles (32 DIV + 1 FIX). HI/LO update at the edge where `busy` falls.
- mthi/mtlo: new value visible the cycle after E0.
- Back-to-back: a new start is accepted in the first cycle `busy` is low and sees the updated HI/LO.
- flush while busy: `busy` is low the cycle after the flush edge.
- `hi`/`lo` are registered outputs with no bypass; mfhi issued while `busy` is high must be stalled upstream.

## Configuration
- `XALU_DIV_EARLY_EN` defined:
  - Early-out applies when divisor magnitude is 0 or dividend magnitude < divisor magnitude.
  - DIV goes straight to FIX, so `busy` lasts 2 cycles.
  - Results are identical to the full algorithm: quotient 0, remainder = `a`; for divide by zero, the values given above.
- Undefined: every div/divu takes 33 busy cycles.

## Test plan
- mult a=32'hFFFFFFFE, b=3 with MUL_LAT=4 -> `busy` high 4 cycles, then HI=32'hFFFFFFFF, LO=32'hFFFFFFFA. multu on the same operands -> HI=2, LO=32'hFFFFFFFA.
- div a=-7, b=2 -> after 33 busy cycles, LO=32'hFFFFFFFD, HI=32'hFFFFFFFF. divu a=7, b=0 -> LO=32'hFFFFFFFF, HI=7; with `XALU_DIV_EARLY_EN`, `busy` lasts 2 cycles.
- mtlo a=32'h1234 then mul a=5, b=-3 -> LO=32'h1234 unchanged, `mul_result`=32'hFFFFFFF1, one-cycle `mul_valid` pulse.
- div started, flush at busy cycle 10 -> `busy` low the next cycle, HI/LO keep prior values. start+flush in the same cycle -> no busy, no change.
- reset asserted mid-div -> `busy`, `hi`, `lo` all 0 the next cycle. A new mult issued right after reset completes normally.
